counter_bus_sequencer: RTL
==========================

Name: counter_bus_sequencer

Overview:
- Upstream host-side sequencer for the 8-bit up/down counter peripheral.
- Accepts one configuration request per valid/ready handshake: PLR, ULR, LLR and CCR values.
- Drives the counter's ncs/nwr/nrd/A1/A0/Din bus to write the four registers, then issues a one-cycle start pulse.
- Waits for the counter's ec (end-cycle) pulse and reports completion status, so software-level stimulus becomes cycle-exact bus traffic.

Parameters:
- DATA_W, 8, width of register data and bus.
- WR_PULSE, 1, number of cycles nwr is held low per register write (1..15).
- TIMEOUT, 1023, maximum WAIT_EC cycles before abort; 0 = wait forever.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  configuration request valid.
- cfg_ready  output  1  sequencer idle and able to accept a request.
- cfg_plr  input  DATA_W  preload value.
- cfg_ulr  input  DATA_W  upper limit.
- cfg_llr  input  DATA_W  lower limit.
- cfg_ccr  input  DATA_W  cycle count.
- ncs  output  1  counter chip select, active-low.
- nwr  output  1  write strobe, active-low.
- nrd  output  1  read strobe, active-low.
- a1  output  1  register address MSB.
- a0  output  1  register address LSB.
- dout  output  DATA_W  write data; top ties Din = dout_en ? dout : z.
- dout_en  output  1  bus drive enable.
- din  input  DATA_W  bus read data (readback only).
- start  output  1  counter start pulse.
- ec  input  1  counter end-cycle pulse.
- err  input  1  counter error flag.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle completion pulse.
- status  output  2  00 ok, 01 range/err, 10 timeout, 11 readback mismatch; held until next accept.

Behaviour:
- All outputs registered.
- Reset values: ncs=1, nwr=1, nrd=1, a1=a0=0, dout=0, dout_en=0, start=0, busy=0, done=0, status=00, cfg_ready=1.
- Accept: cfg_valid && cfg_ready at posedge (cycle 0). cfg_* are latched, cfg_ready drops, busy rises.
- cfg_valid while busy is ignored.
- Pre-check at accept: if plr<llr or plr>ulr, there is no bus activity. done=1 and status=01 in cycle 1; return to IDLE.
- States: IDLE, WR_SETUP, WR_STROBE, RELEASE, [RB_SETUP, RB_SAMPLE], START, WAIT_EC, DONE.
- Write order: PLR (a1a0=00), ULR (01), LLR (10), CCR (11).
- WR_SETUP, 1 cycle: ncs=0, nwr=1, address and dout valid, dout_en=1.
- WR_STROBE, WR_PULSE cycles: nwr=0, address and data stable.
- With WR_PULSE=1, nwr is low in cycles 2, 4, 6, 8.
- RELEASE, 1 cycle: ncs=1, nwr=1, dout_en=0.
- START: start=1 for exactly one cycle (cycle 10 with WR_PULSE=1), ncs=0; then start=0 and enter WAIT_EC. The counter acts on start's falling edge.
- ncs remains 0 through WAIT_EC; returns to 1 in DONE.
- WAIT_EC samples ec and err each posedge. Priority, highest first: err (status 01) > ec (status 00) > timeout (status 10).
- Timeout counter is clog2(TIMEOUT+1) bits wide and saturates. It aborts when the count reaches TIMEOUT; disabled when TIMEOUT=0.
- CCR=0 is legal: the counter may raise ec immediately after start. ec in the first WAIT_EC cycle must be caught.
- DONE: done=1 for one cycle, busy=0, bus idle; cfg_ready=1 in the following cycle.
- Reset mid-operation: all outputs return to reset values immediately. The latched configuration is discarded and no start is issued. Counter registers may be partially written; that is acceptable.
- No arithmetic wrap: comparisons are unsigned DATA_W.

Optional Feature:
- Macro CNT_SEQ_READBACK_EN.
- Defined: after RELEASE, each register is read back in the same order.
  - RB_SETUP, 1 cycle: ncs=0, nrd=1, address.
  - RB_SAMPLE, 1 cycle: nrd=0, din compared against the latched value at the end of the cycle.
  - First mismatch: abort to DONE with status 11, start never asserted.
  - Readback adds 8 cycles before START.
- Undefined: readback states, nrd activity and din are absent; nrd is tied to 1; din is unused.

Test Plan:
- Reset, then cfg 10/15/5/2 → nwr low at cycles 2/4/6/8 with (a1a0, dout) = (00,10), (01,15), (10,5), (11,2); start high at cycle 10 only. Model ec at cycle 40 → done at cycle 41, status 00, cfg_ready=1 at cycle 42.
- cfg plr=20, ulr=15, llr=5 → ncs stays 1 throughout, done at cycle 1, status 01.
- TIMEOUT=50, ec never asserted → done 50 cycles after entering WAIT_EC, status 10, ncs=1.
- Assert reset during the LLR strobe → same-instant return to ncs=1, nwr=1, dout_en=0; no start ever; cfg_ready=1 after release.
- cfg_valid held with new values while busy → ignored; second request accepted only on the cycle after done, with its own values on the bus.
- CNT_SEQ_READBACK_EN, model returns 14 for ULR → status 11, start never asserted, done pulses once.

Source files
------------

// File: rtl/counter_bus_sequencer_if.sv
// Host configuration handshake plus the 8-bit up/down counter peripheral bus.
// master = the sequencer driving the counter bus, slave = host/counter side.
interface counter_bus_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_plr;
  logic [DATA_W-1:0] cfg_ulr;
  logic [DATA_W-1:0] cfg_llr;
  logic [DATA_W-1:0] cfg_ccr;
  logic              ncs;
  logic              nwr;
  logic              nrd;
  logic              a1;
  logic              a0;
  logic [DATA_W-1:0] dout;
  logic              dout_en;
  logic [DATA_W-1:0] din;
  logic              start;
  logic              ec;
  logic              err;
  logic              busy;
  logic              done;
  logic [1:0]        status;

  modport master (
    input  cfg_valid, cfg_plr, cfg_ulr, cfg_llr, cfg_ccr, din, ec, err,
    output cfg_ready, ncs, nwr, nrd, a1, a0, dout, dout_en, start, busy, done, status
  );

  modport slave (
    output cfg_valid, cfg_plr, cfg_ulr, cfg_llr, cfg_ccr, din, ec, err,
    input  cfg_ready, ncs, nwr, nrd, a1, a0, dout, dout_en, start, busy, done, status
  );
endinterface

// File: rtl/counter_bus_sequencer.sv
// Host-side sequencer: writes PLR/ULR/LLR/CCR to the counter, pulses start, waits for ec.
// Optional register readback before start is enabled by defining CNT_SEQ_READBACK_EN.
//
// state     | meaning
// IDLE      | cfg_ready high, waiting for a request
// LATCH     | request latched, limit pre-check evaluated
// WR_SETUP  | ncs low, address/data driven, nwr high
// WR_STROBE | nwr low for WR_PULSE cycles
// RELEASE   | bus released after the fourth write
// RB_SETUP  | readback: ncs low, address driven
// RB_SAMPLE | readback: nrd low, din checked at end of cycle
// START     | one-cycle start pulse
// WAIT_EC   | waiting for ec/err or timeout
// DONE      | one-cycle done pulse, status valid
module counter_bus_sequencer #(
  parameter int DATA_W   = 8,
  parameter int WR_PULSE = 1,
  parameter int TIMEOUT  = 1023
) (
  input logic                     clk,
  input logic                     reset,
  counter_bus_sequencer_if.master bus
);

  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
  localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE - 1);

  typedef enum logic [3:0] {
    IDLE,
    LATCH,
    WR_SETUP,
    WR_STROBE,
    RELEASE,
`ifdef CNT_SEQ_READBACK_EN
    RB_SETUP,
    RB_SAMPLE,
`endif
    START,
    WAIT_EC,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        idx, idx_nx;
  logic [3:0]        pulse_cnt, pulse_nx;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nx;
  logic [DATA_W-1:0] lat [4];
  logic              latch_en;

  logic              ready_q, ready_nx;
  logic              ncs_q, ncs_nx;
  logic              nwr_q, nwr_nx;
  logic [1:0]        addr_q, addr_nx;
  logic [DATA_W-1:0] dout_q, dout_nx;
  logic              dout_en_q, dout_en_nx;
  logic              start_q, start_nx;
  logic              busy_q, busy_nx;
  logic              done_q, done_nx;
  logic [1:0]        status_q, status_nx;
`ifdef CNT_SEQ_READBACK_EN
  logic              nrd_q, nrd_nx;
`endif

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    pulse_nx  = pulse_cnt;
    tmo_nx    = tmo_cnt;
    status_nx = status_q;
    latch_en  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.cfg_valid) begin
          latch_en  = 1'b1;
          status_nx = 2'b00;
          state_nx  = LATCH;
        end
      end
      LATCH: begin
        // Comparisons are unsigned on DATA_W bits; no bus traffic for a bad window.
        if ((lat[0] < lat[2]) || (lat[0] > lat[1])) begin
          status_nx = 2'b01;
          state_nx  = DONE;
        end else begin
          idx_nx   = 2'd0;
          state_nx = WR_SETUP;
        end
      end
      WR_SETUP: begin
        pulse_nx = PULSE_LAST;
        state_nx = WR_STROBE;
      end
      WR_STROBE: begin
        if (pulse_cnt != 4'd0) begin
          pulse_nx = pulse_cnt - 4'd1;
        end else if (idx == 2'd3) begin
          state_nx = RELEASE;
        end else begin
          idx_nx   = idx + 2'd1;
          state_nx = WR_SETUP;
        end
      end
      RELEASE: begin
`ifdef CNT_SEQ_READBACK_EN
        idx_nx   = 2'd0;
        state_nx = RB_SETUP;
`else
        state_nx = START;
`endif
      end
`ifdef CNT_SEQ_READBACK_EN
      RB_SETUP: begin
        state_nx = RB_SAMPLE;
      end
      RB_SAMPLE: begin
        if (bus.din != lat[idx]) begin
          status_nx = 2'b11;
          state_nx  = DONE;
        end else if (idx == 2'd3) begin
          state_nx = START;
        end else begin
          idx_nx   = idx + 2'd1;
          state_nx = RB_SETUP;
        end
      end
`endif
      START: begin
        tmo_nx   = '0;
        state_nx = WAIT_EC;
      end
      WAIT_EC: begin
        if (bus.err) begin
          status_nx = 2'b01;
          state_nx  = DONE;
        end else if (bus.ec) begin
          status_nx = 2'b00;
          state_nx  = DONE;
        end else if ((TIMEOUT > 0) && (tmo_cnt == TMO_LAST)) begin
          status_nx = 2'b10;
          state_nx  = DONE;
        end else if (tmo_cnt != {TMO_W{1'b1}}) begin
          tmo_nx = tmo_cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register together with it.
    ready_nx   = 1'b0;
    ncs_nx     = 1'b1;
    nwr_nx     = 1'b1;
    addr_nx    = 2'b00;
    dout_nx    = '0;
    dout_en_nx = 1'b0;
    start_nx   = 1'b0;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
`ifdef CNT_SEQ_READBACK_EN
    nrd_nx     = 1'b1;
`endif

    case (state_nx)
      IDLE: ready_nx = 1'b1;
      LATCH, RELEASE: busy_nx = 1'b1;
      WR_SETUP, WR_STROBE: begin
        busy_nx    = 1'b1;
        ncs_nx     = 1'b0;
        nwr_nx     = (state_nx != WR_STROBE);
        addr_nx    = idx_nx;
        dout_nx    = lat[idx_nx];
        dout_en_nx = 1'b1;
      end
`ifdef CNT_SEQ_READBACK_EN
      RB_SETUP, RB_SAMPLE: begin
        busy_nx = 1'b1;
        ncs_nx  = 1'b0;
        nrd_nx  = (state_nx != RB_SAMPLE);
        addr_nx = idx_nx;
      end
`endif
      START: begin
        busy_nx  = 1'b1;
        ncs_nx   = 1'b0;
        start_nx = 1'b1;
      end
      WAIT_EC: begin
        busy_nx = 1'b1;
        ncs_nx  = 1'b0;
      end
      DONE: done_nx = 1'b1;
      default: ready_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      pulse_cnt <= 4'd0;
      tmo_cnt   <= '0;
      ready_q   <= 1'b1;
      ncs_q     <= 1'b1;
      nwr_q     <= 1'b1;
      addr_q    <= 2'b00;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= 2'b00;
`ifdef CNT_SEQ_READBACK_EN
      nrd_q     <= 1'b1;
`endif
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      pulse_cnt <= pulse_nx;
      tmo_cnt   <= tmo_nx;
      ready_q   <= ready_nx;
      ncs_q     <= ncs_nx;
      nwr_q     <= nwr_nx;
      addr_q    <= addr_nx;
      dout_q    <= dout_nx;
      dout_en_q <= dout_en_nx;
      start_q   <= start_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      status_q  <= status_nx;
`ifdef CNT_SEQ_READBACK_EN
      nrd_q     <= nrd_nx;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) lat[i] <= '0;
    end else if (latch_en) begin
      lat[0] <= bus.cfg_plr;
      lat[1] <= bus.cfg_ulr;
      lat[2] <= bus.cfg_llr;
      lat[3] <= bus.cfg_ccr;
    end
  end

  assign bus.cfg_ready = ready_q;
  assign bus.ncs       = ncs_q;
  assign bus.nwr       = nwr_q;
  assign bus.a1        = addr_q[1];
  assign bus.a0        = addr_q[0];
  assign bus.dout      = dout_q;
  assign bus.dout_en   = dout_en_q;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;

`ifdef CNT_SEQ_READBACK_EN
  assign bus.nrd = nrd_q;
`else
  logic [DATA_W-1:0] unused_din;
  assign bus.nrd     = 1'b1;
  assign unused_din  = bus.din;
`endif

endmodule
